fifo_drive_arbiter: RTL
=======================

Name: fifo_drive_arbiter

Overview:
- Clocked round-robin arbiter sharing one downstream Fifo-stage drive/free channel between N_REQ upstream requesters.
- Issues at most one downstream drive per cycle, gated by a credit counter sized to downstream depth.
- Records the requester index of each issued token in an in-order tag queue.
- Routes each returning downstream free to the requester that owns the oldest outstanding token.
- Sits between synchronous producers and the pipeline input of a Fifo chain, with all handshake signals as single-cycle pulses in the clk domain.

Parameters:
- N_REQ, 4, number of upstream requesters (2..16)
- CREDITS, 2, downstream tokens allowed in flight; also the tag queue depth (1..8)
- IW, $clog2(N_REQ), requester index width
- CW, $clog2(CREDITS+1), credit counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_drive  in  N_REQ  per-requester drive request pulse
- o_free  out  N_REQ  per-requester free pulse, returned when its token is released downstream
- o_driveNext  out  1  downstream drive pulse
- i_freeNext  in  1  downstream free pulse; one per previously issued drive, in order
- o_grantId  out  IW  index of the requester issued with the current o_driveNext; valid when o_driveNext=1
- o_credit  out  CW  credits currently available
- o_err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0 at a posedge), on the next edge:
  - o_free=0, o_driveNext=0, o_grantId=0, o_credit=CREDITS, o_err=0.
  - All pending flags cleared; tag queue emptied.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - Reset mid-operation drops in-flight tokens and pending requests with no free pulses.
- Pending: pend[i] is set at the edge sampling i_drive[i]=1.
  - pend[i] clears at the edge where requester i is granted.
  - i_drive[i]=1 while pend[i]=1 and i is not granted that edge sets o_err; the request is not double-counted.
- Arbitration, evaluated each edge:
  - Condition: credit>0, any pend, and tag queue not full.
  - Grant the first pending index searching pointer+1, pointer+2, ... mod N_REQ.
  - Registered outputs next cycle: o_driveNext=1 for one cycle, o_grantId=winner.
  - Pointer updates to winner; tag queue pushes winner; credit decrements.
  - Otherwise o_driveNext=0 and o_grantId holds its last value.
- Latency: i_drive sampled at edge k sets pend at k; earliest o_driveNext is high in the cycle after edge k+1. Back-to-back grants are possible every cycle while credit remains.
- Free return: i_freeNext=1 at an edge with a non-empty queue:
  - Pop head tag t.
  - o_free[t]=1 for exactly the next cycle.
  - Credit increments.
- Simultaneous grant and free at the same edge:
  - Credit is unchanged.
  - Queue pushes and pops together; valid even when the queue is full.
  - The freed credit may be reused the same edge: grant is allowed if credit>0 or i_freeNext=1.
- i_freeNext=1 with an empty queue: ignored, credit unchanged, o_err set.
- Credit never exceeds CREDITS and never goes below 0.
- o_err clears only on reset.
- At most one o_free bit is high per cycle.

Optional Feature:
- Macro: FIFOARB_FIRE_EN.
- When defined:
  - Adds port o_fire (out, 1), a registered pulse coincident with every o_driveNext.
  - Adds port o_issueCnt (out, 16), a count of drives issued since reset that wraps 0xFFFF->0.
- When undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset and single request:
  - Hold rst=0 for 2 cycles, then release; expect o_credit=2, o_err=0.
  - Pulse i_drive=4'b0001 at edge 5; expect o_driveNext=1 with o_grantId=0 in the cycle after edge 6.
  - Pulse i_freeNext at edge 10; expect o_free=4'b0001 in the cycle after edge 10.
- Round-robin fairness:
  - Pulse i_drive=4'b1111 together; free each token one cycle after its issue.
  - Expect grant order 0,1,2,3.
  - Re-request all four; expect order 0,1,2,3 again, with the pointer at 3.
- Credit exhaustion (CREDITS=2):
  - Request 0, 1, 2 simultaneously; expect two drives (ids 0, 1) and o_credit=0.
  - Requester 2 stalls until i_freeNext, then is issued the cycle after; o_free[0] precedes o_free[1] (in order).
- Simultaneous free and grant at full credit use:
  - i_freeNext and a new request at the same edge with credit=0.
  - Expect the grant issued, o_credit stays 0, and o_free goes to the head tag.
- Errors:
  - i_freeNext with nothing outstanding -> o_err=1, credit still 2.
  - Double i_drive[3] while pending -> o_err=1, with exactly one grant to 3.
- FIFOARB_FIRE_EN build:
  - 70000 back-to-back issue/free pairs.
  - o_fire matches o_driveNext on every cycle.
  - o_issueCnt = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/fifo_drive_arbiter.sv
// fifo_drive_arbiter: round-robin, credit-gated sharing of one downstream Fifo drive/free channel.
// Optional FIFOARB_FIRE_EN adds o_fire and a 16-bit issue counter o_issueCnt.
module fifo_drive_arbiter #(
  parameter int N_REQ = 4,
  parameter int CREDITS = 2,
  parameter int IW = $clog2(N_REQ),
  parameter int CW = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_drive,
  output logic [N_REQ-1:0] o_free,
  output logic             o_driveNext,
  input  logic             i_freeNext,
  output logic [IW-1:0]    o_grantId,
  output logic [CW-1:0]    o_credit,
  output logic             o_err
`ifdef FIFOARB_FIRE_EN
  ,
  output logic             o_fire,
  output logic [15:0]      o_issueCnt
`endif
);
  localparam int QW = CREDITS > 1 ? $clog2(CREDITS) : 1;
  logic [N_REQ-1:0] pend, gmask;
  logic [IW-1:0] ptr, win;
  logic found, pop, grant;
  logic [IW-1:0] q [CREDITS];
  logic [QW-1:0] head, tail;
  function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
    return p == QW'(CREDITS - 1) ? '0 : p + 1'b1;
  endfunction
  // Descending scan so the nearest pending index after ptr is the last assignment.
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = N_REQ; k >= 1; k--)
      if (pend[IW'((int'(ptr) + k) % N_REQ)]) begin
        win = IW'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
  end
  // Outstanding tokens equal CREDITS - o_credit, so credit 0 means the tag queue is full.
  assign pop = i_freeNext && o_credit != CW'(CREDITS);
  assign grant = found && (o_credit != '0 || pop);
  assign gmask = grant ? N_REQ'(1) << win : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
      ptr <= IW'(N_REQ - 1);
      head <= '0;
      tail <= '0;
      o_free <= '0;
      o_driveNext <= 1'b0;
      o_grantId <= '0;
      o_credit <= CW'(CREDITS);
      o_err <= 1'b0;
    end else begin
      pend <= (pend & ~gmask) | i_drive;
      o_err <= o_err | (|(i_drive & pend & ~gmask)) | (i_freeNext && !pop);
      o_driveNext <= grant;
      if (grant) begin
        o_grantId <= win;
        ptr <= win;
        q[tail] <= win;
        tail <= nxt(tail);
      end
      o_free <= pop ? N_REQ'(1) << q[head] : '0;
      if (pop) head <= nxt(head);
      o_credit <= o_credit - CW'(grant) + CW'(pop);
    end
  end
`ifdef FIFOARB_FIRE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_fire <= 1'b0;
      o_issueCnt <= '0;
    end else begin
      o_fire <= grant;
      if (grant) o_issueCnt <= o_issueCnt + 1'b1;
    end
  end
`endif
endmodule
